key_filter_multi: RTL and testbench

- Parametrised N-channel push-button conditioner; successor to the two-key debounce front end feeding the LED control logic.
- Per key: synchronises the raw active-low input, debounces it, and reports a debounced level plus one-cycle press, release and long-press/auto-repeat events.
- Sits between the board key pins and any consumer logic (LED controllers, menu FSMs).

---
 rtl/key_filter_pkg.sv | 34 +++
 rtl/key_filter_ch.sv | 130 +++++++++++++
 rtl/key_filter_multi.sv | 56 +++++
 tb/tb_key_filter_multi.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// Shared definitions for the multi-key push-button conditioner:
// per-channel state encoding, default 50 MHz timing and width helpers.
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } key_fsm_e;

  localparam int DEF_NUM_KEYS      = 4;
  localparam int DEF_DEB_CYCLES    = 1_000_000;   // 20 ms
  localparam int DEF_LONG_CYCLES   = 50_000_000;  // 1 s
  localparam int DEF_REPEAT_CYCLES = 10_000_000;  // 200 ms
  localparam int DEF_CNT_W         = 26;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input longint unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: two-flop synchroniser, debounce FSM, hold/repeat timer
// and registered level/press/release/long outputs.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam bit               REPEAT_EN = (REPEAT_CYCLES != 0);

  logic             sync_1;
  logic             key_s;
  key_fsm_e         state, state_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             first, first_nxt;
  logic             long_hit;
  logic             press_nxt, release_nxt, long_nxt, level_nxt;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_1 <= 1'b1;
      key_s  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let key_s take the old sync_1, giving two real flop stages.
      sync_1 <= key_in;
      key_s  <= sync_1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      first       <= 1'b0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_nxt;
      hold_cnt    <= hold_nxt;
      first       <= first_nxt;
      key_state   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_long    <= long_nxt;
    end
  end

  assign long_hit = first ? (hold_cnt == LONG_LAST)
                          : (REPEAT_EN && (hold_cnt == REP_LAST));

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_nxt = state;
    deb_nxt   = deb_cnt;
    hold_nxt  = hold_cnt;
    first_nxt = first;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_nxt = FILT_DN;
          deb_nxt   = '0;
        end
      end
      FILT_DN: begin
        if (key_s) begin
          state_nxt = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = DOWN;
          hold_nxt  = '0;
          first_nxt = 1'b1;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      DOWN: begin
        if (key_s) begin
          state_nxt = FILT_UP;
          deb_nxt   = '0;
        end else if (long_hit) begin
          hold_nxt  = '0;
          first_nxt = 1'b0;
        end else if (!first && !REPEAT_EN) begin
          // Repeat disabled: park the timer once the single long pulse is out.
          if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      FILT_UP: begin
        // A bounce back down resumes the hold timer where it was frozen.
        if (!key_s) begin
          state_nxt = DOWN;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    press_nxt   = (state == FILT_DN) && !key_s && (deb_cnt == DEB_LAST);
    release_nxt = (state == FILT_UP) &&  key_s && (deb_cnt == DEB_LAST);
    long_nxt    = (state == DOWN)    && !key_s && long_hit;
    level_nxt   = (state_nxt == DOWN) || (state_nxt == FILT_UP);
  end

endmodule

// File: rtl/key_filter_multi.sv
// N-channel push-button conditioner: replicates key_filter_ch per key pin
// and concatenates the per-channel level and event outputs.
module key_filter_multi
  import key_filter_pkg::*;
#(
  parameter int NUM_KEYS      = DEF_NUM_KEYS,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int MAX_CYCLES = max3(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);

  if (NUM_KEYS < 1 || NUM_KEYS > 32) begin : g_bad_num_keys
    $error("key_filter_multi: NUM_KEYS must be 1..32");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("key_filter_multi: DEB_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("key_filter_multi: LONG_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 0) begin : g_bad_repeat
    $error("key_filter_multi: REPEAT_CYCLES must not be negative");
  end
  if (CNT_W < clog2(longint'(MAX_CYCLES) + 1)) begin : g_bad_cnt_w
    $error("key_filter_multi: CNT_W too small for the longest timing constant");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .Clk        (Clk),
      .Rst        (Rst),
      .key_in     (key_in[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Directed bench for key_filter_multi: table-driven timelines of key_in
// changes and expected output edges, plus hand-written reset sequences.
module tb_key_filter_multi;

  localparam int NK = 2;

  typedef struct {
    int         at;   // edge index relative to the start of the table
    logic [1:0] key;  // key_in value driven after sampling at that edge
    logic [1:0] st;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
  } vec_t;

  logic          Clk;
  logic          Rst;
  logic [NK-1:0] key_in, key_in_nr;
  logic [NK-1:0] key_state, key_press, key_release, key_long;
  logic [NK-1:0] nr_state, nr_press, nr_release, nr_long;
  logic [7:0]    obs;
  bit            sel;
  int            cyc;
  int            n_pass;
  int            n_total;
  vec_t          tbl[$];

  key_filter_multi #(
    .NUM_KEYS(NK), .DEB_CYCLES(16), .LONG_CYCLES(64), .REPEAT_CYCLES(32), .CNT_W(8)
  ) dut (
    .Clk(Clk), .Rst(Rst), .key_in(key_in),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  key_filter_multi #(
    .NUM_KEYS(NK), .DEB_CYCLES(16), .LONG_CYCLES(64), .REPEAT_CYCLES(0), .CNT_W(8)
  ) dut_nr (
    .Clk(Clk), .Rst(Rst), .key_in(key_in_nr),
    .key_state(nr_state), .key_press(nr_press),
    .key_release(nr_release), .key_long(nr_long)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  assign obs = sel ? {nr_state, nr_press, nr_release, nr_long}
                   : {key_state, key_press, key_release, key_long};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {state,press,release,long}=%b want %b", name, got, exp);
  endtask

  function automatic void add(input int at, input logic [1:0] key, input logic [1:0] st,
                              input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] lg);
    vec_t v;
    v.at = at; v.key = key; v.st = st; v.pr = pr; v.rl = rl; v.lg = lg;
    tbl.push_back(v);
  endfunction

  // Called #1 after an edge. Every cycle between rows must be pulse-free
  // with the level of the previous row.
  task automatic run_table(input string name);
    int         base;
    logic [1:0] cur_st;
    base   = cyc;
    cur_st = 2'b00;
    for (int r = 0; r < tbl.size(); r++) begin
      while (cyc < base + tbl[r].at) begin
        @(posedge Clk); #1;
        if (cyc != base + tbl[r].at)
          check($sformatf("%s quiet@%0d", name, cyc - base), obs, {cur_st, 6'b0});
      end
      check($sformatf("%s row%0d@%0d", name, r, tbl[r].at), obs,
            {tbl[r].st, tbl[r].pr, tbl[r].rl, tbl[r].lg});
      cur_st = tbl[r].st;
      if (sel) key_in_nr = tbl[r].key;
      else     key_in    = tbl[r].key;
    end
    tbl.delete();
  endtask

  initial begin
    n_pass = 0; n_total = 0; sel = 1'b0;
    key_in = 2'b11; key_in_nr = 2'b11; Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check($sformatf("reset state %0d", i), obs, 8'h00);
    end
    Rst = 1'b0;

    // Clean press on key0, held 200 edges, then released.
    add(0,   2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(19,  2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(83,  2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
    add(115, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
    add(147, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
    add(179, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
    add(200, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    add(219, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    add(240, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    run_table("clean");

    // Bouncy press: low 10, high 3, then stable low.
    add(0,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    add(13, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(32, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(40, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    add(59, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    add(70, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    run_table("bouncy");

    // Short glitch: three edges low.
    add(0,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    add(40, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    run_table("glitch");

    // Simultaneous press, early release of key1 while key0 repeats.
    add(0,   2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(19,  2'b00, 2'b11, 2'b11, 2'b00, 2'b00);
    add(30,  2'b10, 2'b11, 2'b00, 2'b00, 2'b00);
    add(49,  2'b10, 2'b01, 2'b00, 2'b10, 2'b00);
    add(83,  2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
    add(115, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
    add(120, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    add(139, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    add(150, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    run_table("simul");

    // Reset at hold cycle 40 (edge 59), key0 kept low through and after reset.
    add(0,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(19, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(59, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00);
    run_table("prehold");
    Rst = 1'b1;
    #1;
    check("rst async clear", obs, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check($sformatf("rst held %0d", i), obs, 8'h00);
    end
    Rst = 1'b0;
    add(0,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(19, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(30, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    add(49, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    add(60, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    run_table("postrst");

    // Repeat disabled: one long pulse over a 300-edge hold.
    sel = 1'b1;
    add(0,   2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add(19,  2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
    add(83,  2'b10, 2'b01, 2'b00, 2'b00, 2'b01);
    add(300, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
    add(319, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00);
    add(330, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    run_table("norepeat");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
